// File: rtl/vga_cell_timing.sv
// VGA raster timing with incremental character/tile cell coordinates and a
// programmable delay line that aligns sync/blank/RGB with the drawer latency.
module vga_cell_timing #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int PIPE_DLY  = 2,
  parameter int CELL_W    = 8,
  parameter int CELL_H    = 8,
  parameter int GRID_X0   = 66,
  parameter int GRID_Y0   = 128,
  parameter int GRID_COLS = 52,
  parameter int GRID_ROWS = 40,
  parameter int COLOR_W   = 8,
  localparam int CW  = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1,
  localparam int RW  = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1,
  localparam int IW  = (GRID_COLS * GRID_ROWS > 1) ? $clog2(GRID_COLS * GRID_ROWS) : 1,
  localparam int SXW = (CELL_W > 1) ? $clog2(CELL_W) : 1,
  localparam int SYW = (CELL_H > 1) ? $clog2(CELL_H) : 1
) (
  input  logic               CLK_IN,
  input  logic               RST,
  input  logic               PIX_EN,
  input  logic [COLOR_W-1:0] RGB_IN_R,
  input  logic [COLOR_W-1:0] RGB_IN_G,
  input  logic [COLOR_W-1:0] RGB_IN_B,
  output logic [9:0]         counterX,
  output logic [9:0]         counterY,
  output logic               in_grid,
  output logic [CW-1:0]      cell_col,
  output logic [RW-1:0]      cell_row,
  output logic [IW-1:0]      cell_idx,
  output logic [SXW-1:0]     sub_x,
  output logic [SYW-1:0]     sub_y,
  output logic               line_start,
  output logic               frame_start,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               BLANK,
  output logic               SYNC,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int GX1     = GRID_X0 + GRID_COLS * CELL_W;
  localparam int GY1     = GRID_Y0 + GRID_ROWS * CELL_H;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HA     = 10'(H_ACTIVE);
  localparam logic [9:0] VA     = 10'(V_ACTIVE);
  localparam logic [9:0] HS0    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS0    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] GX0_C  = 10'(GRID_X0);
  localparam logic [9:0] GX1_C  = 10'(GX1);
  localparam logic [9:0] GY0_C  = 10'(GRID_Y0);
  localparam logic [9:0] GY1_C  = 10'(GY1);
  localparam logic [SXW-1:0] SX_LAST = SXW'(CELL_W - 1);
  localparam logic [SYW-1:0] SY_LAST = SYW'(CELL_H - 1);
  localparam logic [IW-1:0]  COLS_C  = IW'(GRID_COLS);
  localparam logic HPOL = (HSYNC_POL != 0);
  localparam logic VPOL = (VSYNC_POL != 0);

  generate
    if (PIPE_DLY < 1) begin : g_chk_dly
      $error("vga_cell_timing: PIPE_DLY must be at least 1");
    end
    if (GX1 > H_ACTIVE || GY1 > V_ACTIVE) begin : g_chk_grid
      $error("vga_cell_timing: cell grid exceeds the active area");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_chk_tot
      $error("vga_cell_timing: totals exceed the 10-bit counters");
    end
  endgenerate

  // run_reg makes the first enabled edge after reset land on (0,0) as a real frame start
  logic           run_reg;
  logic [9:0]     x_next, y_next;
  logic [SXW-1:0] sx_reg, sx_next;
  logic [CW-1:0]  col_reg, col_next;
  logic [SYW-1:0] sy_reg, sy_next;
  logic [RW-1:0]  row_reg, row_next;
  logic [IW-1:0]  base_reg, base_next;
  logic           grid_next;
  logic           active, hs, vs;

  logic [PIPE_DLY-1:0] act_q, hs_q, vs_q;
  logic [PIPE_DLY:0]   act_c, hs_c, vs_c;

  always_comb begin
    x_next    = counterX;
    y_next    = counterY;
    sx_next   = sx_reg;
    col_next  = col_reg;
    sy_next   = sy_reg;
    row_next  = row_reg;
    base_next = base_reg;

    if (!run_reg) begin
      x_next = 10'd0;
      y_next = 10'd0;
    end else if (counterX == H_LAST) begin
      x_next = 10'd0;
      y_next = (counterY == V_LAST) ? 10'd0 : counterY + 10'd1;
    end else begin
      x_next = counterX + 10'd1;
    end

    // Cell counters run freely and restart at the grid origin; outputs mask them outside
    if (x_next == GX0_C) begin
      sx_next  = '0;
      col_next = '0;
    end else if (sx_reg == SX_LAST) begin
      sx_next  = '0;
      col_next = col_reg + CW'(1);
    end else begin
      sx_next = sx_reg + SXW'(1);
    end

    if (x_next == 10'd0) begin
      if (y_next == GY0_C) begin
        sy_next   = '0;
        row_next  = '0;
        base_next = '0;
      end else if (sy_reg == SY_LAST) begin
        sy_next   = '0;
        row_next  = row_reg + RW'(1);
        base_next = base_reg + COLS_C;
      end else begin
        sy_next = sy_reg + SYW'(1);
      end
    end

    grid_next = (x_next >= GX0_C) && (x_next < GX1_C) &&
                (y_next >= GY0_C) && (y_next < GY1_C);
  end

  assign active = run_reg && (counterX < HA) && (counterY < VA);
  assign hs     = run_reg && (counterX >= HS0) && (counterX < HS1);
  assign vs     = run_reg && (counterY >= VS0) && (counterY < VS1);

  assign act_c = {act_q, active};
  assign hs_c  = {hs_q, hs};
  assign vs_c  = {vs_q, vs};

  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) begin
      run_reg     <= 1'b0;
      counterX    <= '0;
      counterY    <= '0;
      sx_reg      <= '0;
      col_reg     <= '0;
      sy_reg      <= '0;
      row_reg     <= '0;
      base_reg    <= '0;
      in_grid     <= 1'b0;
      cell_col    <= '0;
      cell_row    <= '0;
      cell_idx    <= '0;
      sub_x       <= '0;
      sub_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      act_q       <= '0;
      hs_q        <= '0;
      vs_q        <= '0;
      R           <= '0;
      G           <= '0;
      B           <= '0;
    end else if (PIX_EN) begin
      run_reg     <= 1'b1;
      counterX    <= x_next;
      counterY    <= y_next;
      sx_reg      <= sx_next;
      col_reg     <= col_next;
      sy_reg      <= sy_next;
      row_reg     <= row_next;
      base_reg    <= base_next;
      in_grid     <= grid_next;
      cell_col    <= grid_next ? col_next : '0;
      cell_row    <= grid_next ? row_next : '0;
      cell_idx    <= grid_next ? (base_next + IW'(col_next)) : '0;
      sub_x       <= grid_next ? sx_next : '0;
      sub_y       <= grid_next ? sy_next : '0;
      line_start  <= (x_next == 10'd0);
      frame_start <= (x_next == 10'd0) && (y_next == 10'd0);
      act_q       <= act_c[PIPE_DLY-1:0];
      hs_q        <= hs_c[PIPE_DLY-1:0];
      vs_q        <= vs_c[PIPE_DLY-1:0];
      // Colour is captured one stage early so it lands with BLANK
      if (act_c[PIPE_DLY-1]) begin
        R <= RGB_IN_R;
        G <= RGB_IN_G;
        B <= RGB_IN_B;
      end else begin
        R <= '0;
        G <= '0;
        B <= '0;
      end
    end
  end

  assign o_hsync = hs_q[PIPE_DLY-1] ? HPOL : ~HPOL;
  assign o_vsync = vs_q[PIPE_DLY-1] ? VPOL : ~VPOL;
  assign BLANK   = act_q[PIPE_DLY-1];
  assign SYNC    = 1'b0;

endmodule

// File: tb/tb_vga_cell_timing.sv
// Two scaled-down timing builds checked every clock against a position-based
// model: the enabled-edge count fixes raster position, grid cell and delayed outputs.
module tb_vga_cell_timing;

  localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 40, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int GX0 = 6, GY0 = 8;
  localparam int NOUT = 17;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic [7:0] rgb_r, rgb_g, rgb_b;

  int n_en;
  int lr, lg, lb;
  int compared = 0;
  int mismatched = 0;

  logic [31:0] obs   [2][NOUT];
  logic [31:0] exp_v [2][NOUT];
  string names [NOUT] = '{"counterX", "counterY", "in_grid", "cell_col", "cell_row",
                          "cell_idx", "sub_x", "sub_y", "line_start", "frame_start",
                          "o_hsync", "o_vsync", "BLANK", "SYNC", "R", "G", "B"};

  always #5 clk = ~clk;

  logic [9:0] a_cx, a_cy, b_cx, b_cy;
  logic       a_ig, a_ls, a_fs, a_hs, a_vs, a_bl, a_sy;
  logic       b_ig, b_ls, b_fs, b_hs, b_vs, b_bl, b_sy;
  logic [2:0] a_col, a_sx, a_suby;
  logic [1:0] a_row;
  logic [4:0] a_idx, b_idx;
  logic [1:0] b_col;
  logic [2:0] b_row, b_suby;
  logic [3:0] b_sx;
  logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;

  vga_cell_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HSYNC_POL(0), .VSYNC_POL(0), .PIPE_DLY(2),
    .CELL_W(8), .CELL_H(8), .GRID_X0(GX0), .GRID_Y0(GY0),
    .GRID_COLS(6), .GRID_ROWS(3), .COLOR_W(8)
  ) dut_a (
    .CLK_IN(clk), .RST(rst_n), .PIX_EN(pix_en),
    .RGB_IN_R(rgb_r), .RGB_IN_G(rgb_g), .RGB_IN_B(rgb_b),
    .counterX(a_cx), .counterY(a_cy), .in_grid(a_ig),
    .cell_col(a_col), .cell_row(a_row), .cell_idx(a_idx),
    .sub_x(a_sx), .sub_y(a_suby), .line_start(a_ls), .frame_start(a_fs),
    .o_hsync(a_hs), .o_vsync(a_vs), .BLANK(a_bl), .SYNC(a_sy),
    .R(a_r), .G(a_g), .B(a_b)
  );

  vga_cell_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HSYNC_POL(1), .VSYNC_POL(1), .PIPE_DLY(4),
    .CELL_W(12), .CELL_H(5), .GRID_X0(GX0), .GRID_Y0(GY0),
    .GRID_COLS(4), .GRID_ROWS(5), .COLOR_W(8)
  ) dut_b (
    .CLK_IN(clk), .RST(rst_n), .PIX_EN(pix_en),
    .RGB_IN_R(rgb_r), .RGB_IN_G(rgb_g), .RGB_IN_B(rgb_b),
    .counterX(b_cx), .counterY(b_cy), .in_grid(b_ig),
    .cell_col(b_col), .cell_row(b_row), .cell_idx(b_idx),
    .sub_x(b_sx), .sub_y(b_suby), .line_start(b_ls), .frame_start(b_fs),
    .o_hsync(b_hs), .o_vsync(b_vs), .BLANK(b_bl), .SYNC(b_sy),
    .R(b_r), .G(b_g), .B(b_b)
  );

  assign obs[0][0]  = 32'(a_cx);   assign obs[1][0]  = 32'(b_cx);
  assign obs[0][1]  = 32'(a_cy);   assign obs[1][1]  = 32'(b_cy);
  assign obs[0][2]  = 32'(a_ig);   assign obs[1][2]  = 32'(b_ig);
  assign obs[0][3]  = 32'(a_col);  assign obs[1][3]  = 32'(b_col);
  assign obs[0][4]  = 32'(a_row);  assign obs[1][4]  = 32'(b_row);
  assign obs[0][5]  = 32'(a_idx);  assign obs[1][5]  = 32'(b_idx);
  assign obs[0][6]  = 32'(a_sx);   assign obs[1][6]  = 32'(b_sx);
  assign obs[0][7]  = 32'(a_suby); assign obs[1][7]  = 32'(b_suby);
  assign obs[0][8]  = 32'(a_ls);   assign obs[1][8]  = 32'(b_ls);
  assign obs[0][9]  = 32'(a_fs);   assign obs[1][9]  = 32'(b_fs);
  assign obs[0][10] = 32'(a_hs);   assign obs[1][10] = 32'(b_hs);
  assign obs[0][11] = 32'(a_vs);   assign obs[1][11] = 32'(b_vs);
  assign obs[0][12] = 32'(a_bl);   assign obs[1][12] = 32'(b_bl);
  assign obs[0][13] = 32'(a_sy);   assign obs[1][13] = 32'(b_sy);
  assign obs[0][14] = 32'(a_r);    assign obs[1][14] = 32'(b_r);
  assign obs[0][15] = 32'(a_g);    assign obs[1][15] = 32'(b_g);
  assign obs[0][16] = 32'(a_b);    assign obs[1][16] = 32'(b_b);

  // Raster position p (0 = first pixel of the first frame) after reset release
  function automatic int pos_x(int p);
    return p % HT;
  endfunction

  function automatic int pos_y(int p);
    return (p / HT) % VT;
  endfunction

  task automatic compute(input int k, input int d, input int hpol, input int vpol,
                         input int cw, input int ch, input int cols, input int rows);
    int x, y, q, xq, yq;
    bit ing, act, hsa, vsa;
    for (int i = 0; i < NOUT; i++) exp_v[k][i] = 32'd0;
    exp_v[k][10] = 32'(hpol == 0);
    exp_v[k][11] = 32'(vpol == 0);
    if (n_en > 0) begin
      x = pos_x(n_en - 1);
      y = pos_y(n_en - 1);
      exp_v[k][0] = 32'(x);
      exp_v[k][1] = 32'(y);
      exp_v[k][8] = 32'(x == 0);
      exp_v[k][9] = 32'(x == 0 && y == 0);
      ing = (x >= GX0) && (x < GX0 + cols * cw) && (y >= GY0) && (y < GY0 + rows * ch);
      if (ing) begin
        exp_v[k][2] = 32'd1;
        exp_v[k][3] = 32'((x - GX0) / cw);
        exp_v[k][4] = 32'((y - GY0) / ch);
        exp_v[k][5] = 32'(((y - GY0) / ch) * cols + (x - GX0) / cw);
        exp_v[k][6] = 32'((x - GX0) % cw);
        exp_v[k][7] = 32'((y - GY0) % ch);
      end
    end
    q = n_en - 1 - d;
    if (q >= 0) begin
      xq  = pos_x(q);
      yq  = pos_y(q);
      act = (xq < HA) && (yq < VA);
      hsa = (xq >= HA + HFP) && (xq < HA + HFP + HSW);
      vsa = (yq >= VA + VFP) && (yq < VA + VFP + VSW);
      exp_v[k][10] = hsa ? 32'(hpol) : 32'(hpol == 0);
      exp_v[k][11] = vsa ? 32'(vpol) : 32'(vpol == 0);
      exp_v[k][12] = 32'(act);
      if (act) begin
        exp_v[k][14] = 32'(lr);
        exp_v[k][15] = 32'(lg);
        exp_v[k][16] = 32'(lb);
      end
    end
  endtask

  task automatic chk(input int k, input int i);
    compared++;
    assert (obs[k][i] === exp_v[k][i]) else begin
      mismatched++;
      $error("FAIL %s.%s n=%0d observed %0h expected %0h",
             (k == 0) ? "A" : "B", names[i], n_en, obs[k][i], exp_v[k][i]);
    end
  endtask

  task automatic check_all();
    compute(0, 2, 0, 0, 8, 8, 6, 3);
    compute(1, 4, 1, 1, 12, 5, 4, 5);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NOUT; i++) chk(k, i);
  endtask

  // One clock: update the model at the rising edge, compare on the falling edge
  task automatic step();
    @(posedge clk);
    if (rst_n && pix_en) begin
      n_en++;
      lr = int'(rgb_r);
      lg = int'(rgb_g);
      lb = int'(rgb_b);
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic bit at_xy(int x, int y);
    return (n_en > 0) && (pos_x(n_en - 1) == x) && (pos_y(n_en - 1) == y);
  endfunction

  initial begin
    int budget;
    rst_n = 1'b0; pix_en = 1'b0;
    rgb_r = 8'h00; rgb_g = 8'h00; rgb_b = 8'h00;
    n_en = 0; lr = 0; lg = 0; lb = 0;
    repeat (3) step();

    // Constant colour, full rate, one full frame plus margin
    rgb_r = 8'hFF; rgb_g = 8'h00; rgb_b = 8'h80;
    rst_n = 1'b1; pix_en = 1'b1;
    repeat (HT * VT + 200) step();

    // Half pixel rate: enable toggles every clock
    repeat (HT * 6) begin
      pix_en = ~pix_en;
      step();
    end

    // Random enable and random colour
    repeat (6000) begin
      pix_en = ($urandom_range(0, 3) != 0);
      rgb_r = 8'($urandom); rgb_g = 8'($urandom); rgb_b = 8'($urandom);
      step();
    end

    // Asynchronous reset mid-frame at (30,20)
    pix_en = 1'b1;
    budget = 2 * HT * VT;
    while (!at_xy(30, 20) && budget > 0) begin
      step();
      budget--;
    end
    compared++;
    assert (budget > 0) else begin
      mismatched++;
      $error("FAIL reach_30_20 observed n=%0d expected position (30,20) within budget", n_en);
    end
    #2 rst_n = 1'b0;
    #1 n_en = 0;
    check_all();
    repeat (4) step();
    rst_n = 1'b1;
    repeat (HT * VT + 100) begin
      pix_en = ($urandom_range(0, 4) != 0);
      rgb_r = 8'($urandom); rgb_g = 8'($urandom); rgb_b = 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_cell_timing.md
Name: vga_cell_timing

Overview:
- Parametrised VGA timing and cell-grid coordinate generator. It is the next generation of the team's 640x480 drawer timing core.
- Adds configurable timing and sync polarity, a pixel clock-enable, and incremental cell row/column/index generation for a character/tile grid.
- Adds a programmable pipeline delay that aligns sync, blank and RGB with a downstream drawer of arbitrary latency.
- Sits between the 25 MHz clock domain and the DAC pins; the tile/ascii drawer consumes its coordinates and returns RGB.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
HSYNC_POL, 0, active level of o_hsync
VSYNC_POL, 0, active level of o_vsync
PIPE_DLY, 2, stages from coordinates to RGB/sync outputs (>=1)
CELL_W, 8, cell width in pixels
CELL_H, 8, cell height in lines
GRID_X0, 66, first grid pixel column
GRID_Y0, 128, first grid line
GRID_COLS, 52, cells per grid row
GRID_ROWS, 40, grid rows
COLOR_W, 8, bits per colour channel

Ports:
CLK_IN  in  1  pixel clock
RST  in  1  async active-low reset
PIX_EN  in  1  pixel advance enable
RGB_IN_R/G/B  in  COLOR_W each  colour from drawer (stage PIPE_DLY-1)
counterX  out  10  horizontal position, stage 0
counterY  out  10  vertical position, stage 0
in_grid  out  1  stage-0 pixel inside grid
cell_col  out  clog2(GRID_COLS)  grid column
cell_row  out  clog2(GRID_ROWS)  grid row
cell_idx  out  clog2(GRID_COLS*GRID_ROWS)  row*GRID_COLS+col
sub_x  out  clog2(CELL_W)  pixel within cell
sub_y  out  clog2(CELL_H)  line within cell
line_start  out  1  pulse at counterX==0
frame_start  out  1  pulse at counterX==0 && counterY==0
o_hsync  out  1  delayed hsync
o_vsync  out  1  delayed vsync
BLANK  out  1  delayed active-video flag (1 = visible)
SYNC  out  1  tied 0
R/G/B  out  COLOR_W each  registered colour

Behaviour:
- Reset (RST low, async):
  - counterX, counterY, cell_*, sub_*, in_grid, line_start and frame_start are 0.
  - o_hsync and o_vsync are at their inactive level (~POL).
  - BLANK=0 and R/G/B=0.
  - All pipeline stages clear.
  - After release, the first PIX_EN cycle starts the frame at (0,0).
- PIX_EN:
  - Every register, including the pipeline, updates only on a rising CLK_IN edge with PIX_EN=1.
  - With PIX_EN=0 all outputs hold. line_start and frame_start hold too, so they are qualified with PIX_EN.
- Counters:
  - counterX wraps from H_TOTAL-1 to 0, where H_TOTAL is the sum of the four H parameters.
  - counterY increments on the X wrap and wraps from V_TOTAL-1 to 0.
- Stage-0 decode:
  - active = X<H_ACTIVE && Y<V_ACTIVE.
  - hs = X in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs = Y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Grid, incremental only (no dividers or multipliers in the datapath):
  - sub_x and cell_col reset to 0 at X==GRID_X0.
  - sub_x increments and wraps at CELL_W-1; cell_col increments on that wrap.
  - sub_y and cell_row follow the same rule on lines, advancing at each X wrap.
  - cell_idx carries a row base register, increased by GRID_COLS per row, plus cell_col.
  - in_grid = X in [GRID_X0, GRID_X0+GRID_COLS*CELL_W) && Y in [GRID_Y0, GRID_Y0+GRID_ROWS*CELL_H).
  - Outside the grid, cell_col, cell_row, cell_idx, sub_x and sub_y read 0.
  - All grid outputs are aligned to the same cycle as counterX/counterY.
- Pipeline:
  - active, hs and vs pass through PIPE_DLY registers.
  - o_hsync = hs_d ? HSYNC_POL : ~HSYNC_POL; o_vsync likewise with VSYNC_POL.
  - BLANK = active_d.
  - R/G/B register RGB_IN when active delayed PIPE_DLY-1 is set, and 0 otherwise, so colour lands on the same cycle as BLANK.
- Elaboration checks: PIPE_DLY>=1, and the grid fits inside the active area.
- Reset mid-frame clears everything immediately; no partial-frame recovery is needed.

Test Plan:
- Default parameters, PIX_EN=1, run 2 frames:
  - line period is 800 clocks and frame period is 525 lines.
  - o_hsync is low for X 656..751, delayed 2 clocks.
  - o_vsync is low for lines 490..491.
  - frame_start pulses once per 420000 clocks.
- Grid:
  - at X=66, Y=128: in_grid=1, cell_idx=0, sub_x=0.
  - at X=74: cell_col=1.
  - at X=481, Y=447: cell_idx=2079, sub_x=7, sub_y=7.
  - at X=482: in_grid=0 and all grid outputs are 0.
- RGB_IN=FF/00/80 held constant:
  - R/G/B equal FF/00/80 exactly while BLANK=1.
  - R/G/B are 0 during porches.
  - the first nonzero R appears on the same clock as the BLANK rise.
- PIX_EN toggling 1,0 (pixel rate halved):
  - counters advance every other clock and the line spans 1600 clocks.
  - outputs hold while PIX_EN=0.
- Assert RST at X=300, Y=200 mid-frame:
  - outputs immediately take reset values (o_hsync=1 with POL=0).
  - after release, counterX counts from 0.
- Rebuild with PIPE_DLY=4, HSYNC_POL=1, CELL_W=12, GRID_COLS=40:
  - o_hsync is high for X 656..751, delayed 4 clocks.
  - cell_col steps every 12 pixels.
